// File: rtl/car_start_pkg.sv
// car_start_pkg: shared types and constants for the car start sequencer
//   state_t      FSM state encoding
//   IDX_*        sensor mux indices driven on sensor_sel
//   LIM_*        16-bit pass limits (minimums, except engine temp maximum)
//   W_*          bit positions inside warn
package car_start_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LOCKOUT, S_SCAN, S_READY, S_FAULT} state_t;
    localparam logic [2:0] IDX_ENGINE_OIL   = 3'd0;
    localparam logic [2:0] IDX_BATTERY_VOLT = 3'd1;
    localparam logic [2:0] IDX_OIL_PRESSURE = 3'd2;
    localparam logic [2:0] IDX_FUEL_LEVEL   = 3'd3;
    localparam logic [2:0] IDX_WATER_LEVEL  = 3'd4;
    localparam logic [2:0] IDX_TYRE_PRESS   = 3'd5;
    localparam logic [2:0] IDX_ENGINE_TEMP  = 3'd6;
    localparam logic [2:0] IDX_BELT_AIRBAG  = 3'd7;
    localparam logic [15:0] LIM_ENGINE_OIL   = 16'd520;
    localparam logic [15:0] LIM_BATTERY_VOLT = 16'd50;
    localparam logic [15:0] LIM_OIL_PRESSURE = 16'd100;
    localparam logic [15:0] LIM_FUEL_LEVEL   = 16'd1;
    localparam logic [15:0] LIM_WATER_LEVEL  = 16'd400;
    localparam logic [15:0] LIM_TYRE_PRESS   = 16'd70;
    localparam logic [15:0] LIM_ENGINE_TEMP  = 16'd190;
    localparam int W_AIRBAG   = 7;
    localparam int W_SEATBELT = 8;
endpackage

// File: rtl/car_limit_check.sv
// car_limit_check: combinational pass/fail test of one sensor reading
//   index  in  3   sensor index (0..6 checked, 7 never fails)
//   data   in  16  sensor reading, unsigned
//   fail   out 1   reading outside its limit
module car_limit_check
    import car_start_pkg::*;
(
    input  logic [2:0]  index,
    input  logic [15:0] data,
    output logic        fail
);
    always_comb begin
        case (index)
            IDX_ENGINE_OIL:   fail = data < LIM_ENGINE_OIL;
            IDX_BATTERY_VOLT: fail = data < LIM_BATTERY_VOLT;
            IDX_OIL_PRESSURE: fail = data < LIM_OIL_PRESSURE;
            IDX_FUEL_LEVEL:   fail = data < LIM_FUEL_LEVEL;
            IDX_WATER_LEVEL:  fail = data < LIM_WATER_LEVEL;
            IDX_TYRE_PRESS:   fail = data < LIM_TYRE_PRESS;
            IDX_ENGINE_TEMP:  fail = data > LIM_ENGINE_TEMP;
            default:          fail = 1'b0;
        endcase
    end
endmodule

// File: rtl/car_start_sequencer.sv
// car_start_sequencer: PIN unlock with lockout, then continuous sensor scanning
//   clk, rst                 clock, async active-high reset
//   pin_valid, pin           PIN entry strobe and value
//   key_off                  switch-off request (level)
//   sensor_sel, sensor_data  external sensor mux select and reading
//   seatbelt, airbag         sampled at sensor_sel == 7
//   key, locked_out          unlocked / lockout status
//   readytogo, warn          result of last completed scan
//   scan_done                one-cycle pulse when the result updates
module car_start_sequencer
    import car_start_pkg::*;
#(
    parameter logic [15:0] PASSCODE    = 16'd9999,
    parameter int          MAX_TRIES   = 3,
    parameter int          LOCK_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pin_valid,
    input  logic [15:0] pin,
    input  logic        key_off,
    output logic [2:0]  sensor_sel,
    input  logic [15:0] sensor_data,
    input  logic        seatbelt,
    input  logic        airbag,
    output logic        key,
    output logic        locked_out,
    output logic        readytogo,
    output logic [8:0]  warn,
    output logic        scan_done
);
    localparam int TW = $clog2(MAX_TRIES + 1);
    localparam int CW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    state_t          r_state, w_state_nxt;
    logic [TW-1:0]   r_tries, w_tries_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [2:0]      r_sel, w_sel_nxt;
    logic [8:0]      r_shadow, w_shadow_nxt, r_warn, w_warn_nxt, w_final;
    logic            r_ready, w_ready_nxt, r_done, w_done_nxt;
    logic            w_fail;

    car_limit_check u_chk (.index(r_sel), .data(sensor_data), .fail(w_fail));

    // Final scan result folds in the belt/airbag samples taken at index 7
    always_comb begin
        w_final = r_shadow;
        w_final[W_AIRBAG] = r_shadow[W_AIRBAG] | ~airbag;
        w_final[W_SEATBELT] = r_shadow[W_SEATBELT] | ~seatbelt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tries_nxt = r_tries;
        w_cnt_nxt = r_cnt;
        w_sel_nxt = r_sel;
        w_shadow_nxt = r_shadow;
        w_warn_nxt = r_warn;
        w_ready_nxt = r_ready;
        w_done_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (pin_valid && pin == PASSCODE) begin
                    w_state_nxt = S_SCAN;
                    w_tries_nxt = '0;
                    w_sel_nxt = '0;
                end else if (pin_valid && int'(r_tries) + 1 >= MAX_TRIES) begin
                    w_state_nxt = S_LOCKOUT;
                    w_tries_nxt = TW'(MAX_TRIES);
                    w_cnt_nxt = CW'(LOCK_CYCLES - 1);
                end else if (pin_valid) begin
                    w_tries_nxt = r_tries + TW'(1);
                end
            end
            S_LOCKOUT: begin
                w_state_nxt = (r_cnt == '0) ? S_IDLE : S_LOCKOUT;
                w_tries_nxt = (r_cnt == '0) ? '0 : r_tries;
                w_cnt_nxt = (r_cnt == '0) ? '0 : r_cnt - CW'(1);
            end
            default: begin
                // SCAN, READY and FAULT all scan; they differ only in the last verdict
                if (key_off) begin
                    w_state_nxt = S_IDLE;
                    w_sel_nxt = '0;
                    w_shadow_nxt = '0;
                    w_warn_nxt = '0;
                    w_ready_nxt = 1'b0;
                end else if (r_sel == IDX_BELT_AIRBAG) begin
                    w_sel_nxt = '0;
                    w_shadow_nxt = '0;
                    w_warn_nxt = w_final;
                    w_ready_nxt = (w_final == '0);
                    w_done_nxt = 1'b1;
                    w_state_nxt = (w_final == '0) ? S_READY : S_FAULT;
                end else begin
                    w_sel_nxt = r_sel + 3'd1;
                    w_shadow_nxt[r_sel] = r_shadow[r_sel] | w_fail;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_tries <= '0;
            r_cnt <= '0;
            r_sel <= '0;
            r_shadow <= '0;
            r_warn <= '0;
            r_ready <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tries <= w_tries_nxt;
            r_cnt <= w_cnt_nxt;
            r_sel <= w_sel_nxt;
            r_shadow <= w_shadow_nxt;
            r_warn <= w_warn_nxt;
            r_ready <= w_ready_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign key = (r_state == S_SCAN) || (r_state == S_READY) || (r_state == S_FAULT);
    assign locked_out = (r_state == S_LOCKOUT);
    assign readytogo = r_ready;
    assign warn = r_warn;
    assign scan_done = r_done;
    assign sensor_sel = r_sel;
endmodule
